mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched load/store control (valid, dram_we, sl_type, ALU address, rD2 store data) into requests on a req/gnt/rvalid data bus.
- Asserts a pipeline stall while a bus transaction is outstanding.
- Returns aligned, sign- or zero-extended load data to the MEM/WB path.

Parameters:
TIMEOUT_CYCLES, 256, cycles spent in REQ+RESP before the transaction is abandoned (bus error)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
instr_valid_mem_i  input  1  MEM-stage instruction valid
dram_we_mem_i  input  1  1 = store, 0 = load or none
alu_result_mem_i  input  32  byte address
rD2_mem_i  input  32  store data
sl_type_mem_i  input  4  0=none 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; others = none
dbus_req_o  output  1  bus request
dbus_we_o  output  1  bus write
dbus_addr_o  output  32  word address (low 2 bits zero)
dbus_wstrb_o  output  4  byte write strobes
dbus_wdata_o  output  32  lane-replicated store data
dbus_gnt_i  input  1  request accepted this cycle
dbus_rvalid_i  input  1  read data valid
dbus_rdata_i  input  32  read word
stall_o  output  1  freeze IF..EX/MEM pipeline registers
load_data_o  output  32  extended load result
load_valid_o  output  1  load completes this cycle
misalign_o  output  1  misaligned access, 1-cycle pulse
bus_err_o  output  1  timeout, 1-cycle pulse

Behaviour:
- Access decode:
  - load = valid & !dram_we & sl_type in 1..5
  - store = valid & dram_we & sl_type in 6..8
  - all other combinations are no access: no request, no stall.
- Misalignment:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
  - In IDLE, a misaligned access pulses misalign_o for one cycle. No request, no stall, state stays IDLE.
- start = (load|store) & !misaligned & state==IDLE.
- States IDLE, REQ, RESP. At start, addr (word-aligned), we, wstrb, wdata, sl_type and addr[1:0] are registered and the next state is REQ.
- IDLE: stall_o = start.
- REQ:
  - dbus_req_o=1 and all bus outputs come from the registered copies; they stay stable until gnt.
  - On gnt with a store: go to IDLE, stall_o=0 this cycle (completion).
  - On gnt with a load: go to RESP, stall_o=1.
  - No gnt: stay in REQ, stall_o=1.
- RESP:
  - dbus_req_o=0.
  - On rvalid: load_valid_o=1, load_data_o = extended rdata (combinational this cycle), data registered into the hold register, stall_o=0, go to IDLE.
  - No rvalid: stall_o=1.
- Minimum latency: store = 1 stall cycle; load = 2 stall cycles.
- Because stall_o=0 in the completion cycle, the next instruction enters MEM on the same edge and no re-issue occurs.
- Store formatting:
  - SB: strobe 4'b0001<<addr[1:0], data {4{rD2[7:0]}}.
  - SH: strobe 4'b0011<<(2*addr[1]), data {2{rD2[15:0]}}.
  - SW: strobe 4'b1111, data rD2.
- Load formatting:
  - byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]).
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- load_data_o outside the completion cycle = last loaded value (hold register).
- Timeout:
  - Counter clears at start and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion: bus_err_o pulse, stall_o=0, load_data_o=0 that cycle, hold register cleared, go to IDLE.
  - Completion in the same cycle as the limit wins; no error.
- Reset (any state, including mid-transaction): after the edge, state=IDLE. dbus_req_o, stall_o, load_valid_o, misalign_o and bus_err_o are all 0. The hold register and counter are 0. Registered bus fields are 0. A late gnt/rvalid is ignored.
- gnt or rvalid arriving in an unexpected state is ignored.

Test Plan:
- SW addr 0x100, rD2 0xDEADBEEF, gnt in first REQ cycle -> req=1, addr 0x100, wstrb 1111, wdata 0xDEADBEEF; stall high exactly 1 cycle.
- SB addr 0x103, rD2 0x12345AA -> wstrb 1000, wdata 0xAAAAAAAA; SH addr 0x102, rD2 0xBEEF -> wstrb 1100, wdata 0xBEEFBEEF.
- LB addr 0x101, rdata 0x00008000 with gnt and rvalid delayed 3 cycles each -> load_data 0xFFFFFF80 (LBU: 0x00000080); stall high for all wait cycles; load_valid for exactly 1 cycle.
- LW addr 0x102 -> misalign_o for 1 cycle, no req, no stall; sl_type=3 with dram_we=1 -> no access.
- Load never gets rvalid, TIMEOUT_CYCLES=8 -> bus_err_o at cycle 8 after start; stall drops; load_data 0.
- rst asserted in RESP, then rvalid arrives -> req/stall 0 the next cycle; load_valid never asserted.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store engine. Takes the EX/MEM register outputs
//   (valid, dram_we, sl_type, ALU byte address, rD2 store data) and turns
//   them into requests on a req/gnt/rvalid data bus. While a transaction
//   is outstanding it holds the pipeline with stall_o. It returns
//   aligned, sign- or zero-extended load data toward MEM/WB.
//
// Bus handshake:
//   dbus_req_o stays high, with addr/we/wstrb/wdata held stable, until the
//   cycle in which dbus_gnt_i is seen high. A store completes in that grant
//   cycle. A load then waits in RESP for dbus_rvalid_i, and the word on
//   dbus_rdata_i is consumed in that same cycle. A gnt or rvalid that
//   arrives when the unit is not waiting for it is ignored.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   instr_valid_mem_i      MEM-stage instruction valid
//   dram_we_mem_i          1 = store, 0 = load or none
//   alu_result_mem_i[31:0] byte address
//   rD2_mem_i[31:0]        store data
//   sl_type_mem_i[3:0]     0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
//   dbus_*                 data bus (word address, byte strobes, replicated data)
//   stall_o                freeze IF..EX/MEM pipeline registers
//   load_data_o[31:0]      extended load result; holds the last loaded value
//   load_valid_o           load completes this cycle
//   misalign_o             misaligned access (single pulse, no bus traffic)
//   bus_err_o              transaction timed out (single pulse)
//   dbg_state[1:0]         FSM state: 0 IDLE, 1 REQ, 2 RESP
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_mem_i,
  input  logic        dram_we_mem_i,
  input  logic [31:0] alu_result_mem_i,
  input  logic [31:0] rD2_mem_i,
  input  logic [3:0]  sl_type_mem_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_wstrb_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] SL_LB  = 4'd1;
  localparam logic [3:0] SL_LBU = 4'd2;
  localparam logic [3:0] SL_LH  = 4'd3;
  localparam logic [3:0] SL_LHU = 4'd4;
  localparam logic [3:0] SL_LW  = 4'd5;
  localparam logic [3:0] SL_SB  = 4'd6;
  localparam logic [3:0] SL_SH  = 4'd7;
  localparam logic [3:0] SL_SW  = 4'd8;

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic [3:0]    sl_q;
  logic [1:0]    off_q;
  logic [31:0]   hold_q;

  // Access decode
  logic is_load_type, is_store_type, load_acc, store_acc, access;
  logic half_acc, word_acc, misaligned;
  logic [3:0]  new_wstrb;
  logic [31:0] new_wdata;

  always_comb begin
    is_load_type  = (sl_type_mem_i >= SL_LB) && (sl_type_mem_i <= SL_LW);
    is_store_type = (sl_type_mem_i >= SL_SB) && (sl_type_mem_i <= SL_SW);
    load_acc      = instr_valid_mem_i && !dram_we_mem_i && is_load_type;
    store_acc     = instr_valid_mem_i &&  dram_we_mem_i && is_store_type;
    access        = load_acc || store_acc;
    half_acc      = (sl_type_mem_i == SL_LH) || (sl_type_mem_i == SL_LHU) ||
                    (sl_type_mem_i == SL_SH);
    word_acc      = (sl_type_mem_i == SL_LW) || (sl_type_mem_i == SL_SW);
    misaligned    = (half_acc && alu_result_mem_i[0]) ||
                    (word_acc && (alu_result_mem_i[1:0] != 2'b00));
  end

  // Store lane formatting; loads register zero strobes and data
  always_comb begin
    new_wstrb = 4'b0000;
    new_wdata = 32'h0;
    if (store_acc) begin
      case (sl_type_mem_i)
        SL_SB: begin
          new_wstrb = 4'b0001 << alu_result_mem_i[1:0];
          new_wdata = {4{rD2_mem_i[7:0]}};
        end
        SL_SH: begin
          new_wstrb = alu_result_mem_i[1] ? 4'b1100 : 4'b0011;
          new_wdata = {2{rD2_mem_i[15:0]}};
        end
        default: begin
          new_wstrb = 4'b1111;
          new_wdata = rD2_mem_i;
        end
      endcase
    end
  end

  // Load extraction from the returned word, using the registered offset/type
  logic [31:0] byte_sh, half_sh, load_ext;

  always_comb begin
    byte_sh  = dbus_rdata_i >> {off_q, 3'b000};
    half_sh  = dbus_rdata_i >> {off_q[1], 4'b0000};
    load_ext = dbus_rdata_i;
    case (sl_q)
      SL_LB:   load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      SL_LBU:  load_ext = {24'h0, byte_sh[7:0]};
      SL_LH:   load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      SL_LHU:  load_ext = {16'h0, half_sh[15:0]};
      default: load_ext = dbus_rdata_i;
    endcase
  end

  // Next state and outputs
  logic start, at_limit;

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    stall_o      = 1'b0;
    dbus_req_o   = 1'b0;
    load_valid_o = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    load_data_o  = hold_q;
    at_limit     = (cnt_q == LIMIT);
    case (state_q)
      S_IDLE: begin
        if (access && misaligned) begin
          misalign_o = 1'b1;
        end else if (access) begin
          start   = 1'b1;
          stall_o = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        dbus_req_o = 1'b1;
        // A store grant is completion and beats the timeout; a load grant
        // is not completion, so at the limit it still times out.
        if (dbus_gnt_i && we_q) begin
          state_d = S_IDLE;
        end else if (at_limit) begin
          bus_err_o   = 1'b1;
          load_data_o = 32'h0;
          state_d     = S_IDLE;
        end else if (dbus_gnt_i) begin
          stall_o = 1'b1;
          state_d = S_RESP;
        end else begin
          stall_o = 1'b1;
        end
      end
      S_RESP: begin
        if (dbus_rvalid_i) begin
          load_valid_o = 1'b1;
          load_data_o  = load_ext;
          state_d      = S_IDLE;
        end else if (at_limit) begin
          bus_err_o   = 1'b1;
          load_data_o = 32'h0;
          state_d     = S_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      sl_q    <= 4'd0;
      off_q   <= 2'b00;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q   <= '0;
        addr_q  <= {alu_result_mem_i[31:2], 2'b00};
        we_q    <= dram_we_mem_i;
        wstrb_q <= new_wstrb;
        wdata_q <= new_wdata;
        sl_q    <= sl_type_mem_i;
        off_q   <= alu_result_mem_i[1:0];
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (load_valid_o) begin
        hold_q <= load_ext;
      end else if (bus_err_o) begin
        hold_q <= 32'h0;
      end
    end
  end

  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wstrb_o = wstrb_q;
  assign dbus_wdata_o = wdata_q;
  assign dbg_state    = state_q;

endmodule
